valet_dispatcher: RTL and testbench



---
 rtl/valet_pkg.sv | 45 ++++
 rtl/valet_arbiter.sv | 46 ++++
 rtl/valet_dispatcher.sv | 181 ++++++++++++++++++
 tb/tb_valet_dispatcher.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/valet_pkg.sv
// valet_pkg: shared types and helpers for the valet dispatcher slice.
//   persona_e : arbitration policy selector
//   op_e      : requester job type
//   state_e   : dispatcher FSM states
//   LFSR_TAPS : feedback mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   first_free: lowest-index free slot of an occupancy vector
package valet_pkg;

    typedef enum logic [1:0] {
        STRATEGIST,
        GAMBLER,
        MINIMALIST,
        RECKLESS
    } persona_e;

    typedef enum logic {
        OP_PARK,
        OP_RETRIEVE
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_e;

    // Bits 7,5,4,3 of the shift register correspond to taps 8,6,5,4.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Widest garage the slice supports; occupancy is zero-extended to this.
    localparam int MAX_SLOTS = 64;

    // Returns the lowest index s < n_slots with occ[s]==0, or n_slots when
    // every slot in range is taken. Callers gate the result with a full check.
    function automatic logic [6:0] first_free(input logic [MAX_SLOTS-1:0] occ,
                                              input int                   n_slots);
        logic [6:0] idx;
        idx = 7'(n_slots);
        for (int s = MAX_SLOTS - 1; s >= 0; s--) begin
            if (s < n_slots && !occ[s]) idx = 7'(s);
        end
        return idx;
    endfunction

endpackage

// File: rtl/valet_arbiter.sv
// valet_arbiter: combinational requester selection for the valet.
//   req_valid : pending-job vector
//   mode      : policy (rotating search for STRATEGIST/GAMBLER, fixed low or
//               high priority for MINIMALIST/RECKLESS)
//   start     : first index examined by the rotating search
//   grant     : one-hot winner (all zero when nothing is valid)
//   grant_idx : binary index of the winner
//   grant_any : a winner exists
module valet_arbiter
    import valet_pkg::*;
#(
    parameter int  N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  persona_e         mode,
    input  logic [IDX_W-1:0] start,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    // One priority walk serves every policy: only the order in which
    // candidates are visited changes.
    always_comb begin
        int cand;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            case (mode)
                STRATEGIST,
                GAMBLER:    cand = (int'(start) + k) % N_REQ;
                MINIMALIST: cand = k;
                default:    cand = N_REQ - 1 - k;
            endcase
            if (!grant_any && req_valid[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/valet_dispatcher.sv
// valet_dispatcher: sequences one shared valet across N_REQ requesters that
// park cars into / retrieve cars from an N_SLOTS garage.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/op/slot  : per-requester job (op 0=PARK, 1=RETRIEVE; slot used
//                        by RETRIEVE only), sampled at the handshake
//   req_ready          : one-hot grant, only ever high while IDLE
//   done_valid/id/slot/ok : one-cycle completion report
//   occupancy          : bit s set when slot s holds a car
//   busy               : dispatcher is not IDLE
module valet_dispatcher
    import valet_pkg::*;
#(
    parameter int         N_REQ        = 4,
    parameter int         N_SLOTS      = 8,
    parameter int         DRIVE_CYCLES = 4,
    parameter persona_e   ARB_MODE     = STRATEGIST,
    parameter logic [7:0] LFSR_SEED    = 8'hA5,
    localparam int        SLOT_W       = $clog2(N_SLOTS),
    localparam int        IDX_W        = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0]             req_op,
    input  logic [N_REQ-1:0][SLOT_W-1:0] req_slot,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         done_valid,
    output logic [IDX_W-1:0]             done_id,
    output logic [SLOT_W-1:0]            done_slot,
    output logic                         done_ok,
    output logic [N_SLOTS-1:0]           occupancy,
    output logic                         busy
);

    // RECKLESS halves the drive time but never drops below one cycle.
    localparam int HALF_DRIVE = (DRIVE_CYCLES / 2 > 1) ? DRIVE_CYCLES / 2 : 1;
    localparam int DRIVE_TIME = (ARB_MODE == RECKLESS) ? HALF_DRIVE : DRIVE_CYCLES;
    localparam int CNT_W      = $clog2(DRIVE_CYCLES + 1);

    state_e              state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [7:0]          lfsr;
    logic [CNT_W-1:0]    cnt;

    // Job latched at grant; occupancy cannot change while it is in flight,
    // so the accept/refuse decision made at grant stays valid.
    logic [IDX_W-1:0]    job_id;
    op_e                 job_op;
    logic [SLOT_W-1:0]   job_slot;

    logic [IDX_W-1:0]    arb_start;
    logic [N_REQ-1:0]    grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_any;

    op_e                 g_op;
    logic [SLOT_W-1:0]   g_slot;
    logic                g_ok;
    logic                garage_full;
    logic [6:0]          free_idx;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        case (ARB_MODE)
            STRATEGIST: arb_start = rr_ptr;
            GAMBLER:    arb_start = IDX_W'(32'(lfsr) % N_REQ);
            default:    arb_start = '0;
        endcase
    end

    valet_arbiter #(
        .N_REQ (N_REQ)
    ) u_arbiter (
        .req_valid (req_valid),
        .mode      (ARB_MODE),
        .start     (arb_start),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = (state == IDLE) ? grant : '0;

    // ------------------------------------------------------------------
    // Decide the winner's job outcome at grant time
    // ------------------------------------------------------------------
    always_comb begin
        g_op        = op_e'(req_op[grant_idx]);
        garage_full = &occupancy;
        free_idx    = first_free(MAX_SLOTS'(occupancy), N_SLOTS);
        g_ok        = 1'b0;
        g_slot      = '0;
        if (g_op == OP_PARK) begin
            g_ok   = !garage_full;
            g_slot = garage_full ? '0 : SLOT_W'(free_idx);
        end else begin
            // A refused retrieve still reports the slot that was asked for.
            g_slot = req_slot[grant_idx];
            g_ok   = (32'(req_slot[grant_idx]) < N_SLOTS) && occupancy[req_slot[grant_idx]];
        end
    end

    // ------------------------------------------------------------------
    // Dispatcher FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            lfsr       <= LFSR_SEED;
            cnt        <= '0;
            job_id     <= '0;
            job_op     <= OP_PARK;
            job_slot   <= '0;
            occupancy  <= '0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_slot  <= '0;
            done_ok    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Free-running so the Gambler start point keeps moving even
            // while the valet is out on a drive.
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        job_id   <= grant_idx;
                        job_op   <= g_op;
                        job_slot <= g_slot;
                        rr_ptr   <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0
                                                                     : grant_idx + IDX_W'(1);
                        busy     <= 1'b1;
                        if (g_ok) begin
                            state <= DRIVE;
                            cnt   <= CNT_W'(DRIVE_TIME - 1);
                        end else begin
                            // Refused jobs never drive; report on the next cycle.
                            state      <= DONE;
                            done_valid <= 1'b1;
                            done_id    <= grant_idx;
                            done_slot  <= g_slot;
                            done_ok    <= 1'b0;
                        end
                    end
                end

                DRIVE: begin
                    if (cnt == '0) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                        done_id    <= job_id;
                        done_slot  <= job_slot;
                        done_ok    <= 1'b1;
                        occupancy[job_slot] <= (job_op == OP_PARK);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    done_valid <= 1'b0;
                    done_id    <= '0;
                    done_slot  <= '0;
                    done_ok    <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_valet_dispatcher.sv
// tb_valet_dispatcher: five dispatcher instances (each arbitration mode with
// an 8-slot garage and 4-cycle drive, plus a 6-slot / 1-cycle STRATEGIST) share
// one stimulus stream. A transaction-level model per instance predicts
// grants, completion cycles and garage contents from the job rules.
module tb_valet_dispatcher;
    import valet_pkg::*;

    localparam int N_REQ = 4;
    localparam int N_DUT = 5;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_op;
    logic [N_REQ-1:0][2:0]  req_slot;

    int n_chk = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Winner per mode: 0 rotate from rr, 1 rotate from lfsr mod N,
    // 2 lowest index, 3 highest index. -1 when nobody is asking.
    function automatic int pick(input int p, input logic [N_REQ-1:0] v, input int rr, input int lf);
        int start;
        start = (p == 1) ? (lf % N_REQ) : rr;
        for (int k = 0; k < N_REQ; k++) begin
            int c;
            if (p == 2)      c = k;
            else if (p == 3) c = N_REQ - 1 - k;
            else             c = (start + k) % N_REQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam persona_e P  = (g == 1) ? GAMBLER : (g == 2) ? MINIMALIST :
                                  (g == 3) ? RECKLESS : STRATEGIST;
        localparam int       PI = (g < 4) ? g : 0;
        localparam int       NS = (g == 4) ? 6 : 8;
        localparam int       DC = (g == 4) ? 1 : 4;

        logic [N_REQ-1:0] rdy;
        logic             dv;
        logic [1:0]       did;
        logic [2:0]       dslot;
        logic             dok;
        logic [NS-1:0]    occ;
        logic             bsy;

        valet_dispatcher #(
            .N_REQ        (N_REQ),
            .N_SLOTS      (NS),
            .DRIVE_CYCLES (DC),
            .ARB_MODE     (P),
            .LFSR_SEED    (8'hA5)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid),
            .req_op     (req_op),
            .req_slot   (req_slot),
            .req_ready  (rdy),
            .done_valid (dv),
            .done_id    (did),
            .done_slot  (dslot),
            .done_ok    (dok),
            .occupancy  (occ),
            .busy       (bsy)
        );

        // Model state: garage contents, in-flight job and the cycle its
        // report is due.
        bit m_occ [NS];
        int m_rr, m_lfsr, m_cyc, m_t, m_id, m_slot;
        bit m_busy, m_ok, m_op;

        always @(negedge clk) begin : model
            int            w, dt, ff;
            bit            e_dv;
            logic [NS-1:0] e_occ;
            if (!rst_n) begin
                for (int s = 0; s < NS; s++) m_occ[s] = 1'b0;
                m_rr = 0; m_lfsr = 8'hA5; m_cyc = 0; m_t = 0; m_busy = 1'b0;
                chk($sformatf("u%0d_rst_rdy", g),  rdy,   0);
                chk($sformatf("u%0d_rst_dv", g),   dv,    0);
                chk($sformatf("u%0d_rst_id", g),   did,   0);
                chk($sformatf("u%0d_rst_slot", g), dslot, 0);
                chk($sformatf("u%0d_rst_ok", g),   dok,   0);
                chk($sformatf("u%0d_rst_occ", g),  occ,   0);
                chk($sformatf("u%0d_rst_busy", g), bsy,   0);
            end else begin
                e_dv = m_busy && (m_cyc == m_t);
                if (e_dv && m_ok) m_occ[m_slot] = (m_op == 1'b0);
                w = m_busy ? -1 : pick(PI, req_valid, m_rr, m_lfsr);
                for (int s = 0; s < NS; s++) e_occ[s] = m_occ[s];

                chk($sformatf("u%0d_ready", g), rdy, (w >= 0) ? (32'd1 << w) : 32'd0);
                chk($sformatf("u%0d_done_valid", g), dv, e_dv);
                chk($sformatf("u%0d_occupancy", g), occ, e_occ);
                chk($sformatf("u%0d_busy", g), bsy, m_busy);
                if (e_dv) begin
                    chk($sformatf("u%0d_done_id", g), did, m_id);
                    chk($sformatf("u%0d_done_ok", g), dok, m_ok);
                    if (m_ok || m_op == 1'b0)
                        chk($sformatf("u%0d_done_slot", g), dslot, m_slot);
                    m_busy = 1'b0;
                end

                if (w >= 0) begin
                    m_busy = 1'b1;
                    m_id   = w;
                    m_op   = req_op[w];
                    if (m_op == 1'b0) begin
                        ff = -1;
                        for (int s = 0; s < NS; s++) if (!m_occ[s] && ff < 0) ff = s;
                        m_ok   = (ff >= 0);
                        m_slot = m_ok ? ff : 0;
                    end else begin
                        m_slot = int'(req_slot[w]);
                        m_ok   = (m_slot < NS) && m_occ[m_slot];
                    end
                    dt   = (PI == 3) ? ((DC / 2 > 1) ? DC / 2 : 1) : DC;
                    m_t  = m_cyc + (m_ok ? dt + 1 : 1);
                    m_rr = (w + 1) % N_REQ;
                end

                m_lfsr = ((m_lfsr << 1) & 8'hFF) |
                         (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1);
                m_cyc++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = N_REQ'($urandom);
            req_op    = N_REQ'($urandom) & N_REQ'($urandom);
            for (int r = 0; r < N_REQ; r++) req_slot[r] = 3'($urandom);
            step();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_slot  = '0;
        repeat (3) step();
        rst_n = 1'b1;

        // Lone PARK from requester 2, then let every instance drain.
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (8) step();

        // Everyone parks continuously: round-robin order, garage fills,
        // later parks are refused.
        req_valid = 4'hF;
        req_op    = 4'h0;
        repeat (70) step();

        // Repeated RETRIEVE of slot 3: first succeeds, the rest are refused.
        req_valid   = 4'b0010;
        req_op      = 4'b0010;
        req_slot[1] = 3'd3;
        repeat (15) step();

        // Only the two extreme requesters contend.
        req_valid = 4'b1001;
        for (int i = 0; i < 20; i++) begin
            req_op = N_REQ'($urandom);
            for (int r = 0; r < N_REQ; r++) req_slot[r] = 3'($urandom);
            step();
        end

        rand_cycles(300);

        // Reset lands while the drive of a PARK is in progress.
        req_valid = '0;
        repeat (8) step();
        req_valid = 4'b0001;
        req_op    = 4'h0;
        step();
        req_valid = '0;
        repeat (2) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n     = 1'b1;
        req_valid = 4'hF;
        req_op    = 4'h0;
        step();

        rand_cycles(400);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
